// File: rtl/nv_fork_pkg.sv
// Shared types and constants for the valid/ready broadcast fork.
package nv_fork_pkg;

  // Per-branch delivery state for the currently buffered payload.
  typedef enum logic {
    PEND = 1'b0,
    DONE = 1'b1
  } br_state_t;

  localparam int NV_FORK_NBR = 2;

endpackage

// File: rtl/nv_fork_branch.sv
// One consumer branch of the fork: tracks whether this branch has already
// taken the buffered payload.
module nv_fork_branch
  import nv_fork_pkg::*;
(
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  input  logic buf_vld,
  input  logic prdy,
  input  logic retire,
  input  logic accept,
  output logic pvld,
  output logic ready_or_done
);

  br_state_t br;

  assign pvld          = buf_vld & (br == PEND);
  // A branch that already took the payload no longer holds up retirement.
  assign ready_or_done = (br == DONE) | prdy;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      br <= PEND;
    end else if (accept || retire) begin
      br <= PEND;
    end else if (pvld && prdy) begin
      br <= DONE;
    end
  end

endmodule

// File: rtl/nv_vld_rdy_fork2.sv
// Registered one-to-two broadcast fork: one upstream payload is held until
// both downstream branches have taken it exactly once.
module nv_vld_rdy_fork2
  import nv_fork_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out0_pvld,
  input  logic             out0_prdy,
  output logic [WIDTH-1:0] out0_pd,
  output logic             out1_pvld,
  input  logic             out1_prdy,
  output logic [WIDTH-1:0] out1_pd
);

  logic             buf_vld;
  logic [WIDTH-1:0] buf_pd;
  logic             retire;
  logic             accept;

  logic [NV_FORK_NBR-1:0] br_prdy;
  logic [NV_FORK_NBR-1:0] br_pvld;
  logic [NV_FORK_NBR-1:0] br_rod;

  assign br_prdy = {out1_prdy, out0_prdy};

  for (genvar k = 0; k < NV_FORK_NBR; k++) begin : g_branch
    nv_fork_branch u_branch (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .buf_vld         (buf_vld),
      .prdy            (br_prdy[k]),
      .retire          (retire),
      .accept          (accept),
      .pvld            (br_pvld[k]),
      .ready_or_done   (br_rod[k])
    );
  end

  // Retiring frees the buffer in the same cycle, so the next payload loads
  // without a bubble; in_prdy never depends on in_pvld.
  assign retire  = buf_vld & (&br_rod);
  assign in_prdy = ~buf_vld | retire;
  assign accept  = in_pvld & in_prdy;

  // NOTE: the payload register is reset too, so the outputs never carry X
  // before the first accepted payload.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      buf_vld <= 1'b0;
      buf_pd  <= '0;
    end else if (accept) begin
      buf_vld <= 1'b1;
      buf_pd  <= in_pd;
    end else if (retire) begin
      buf_vld <= 1'b0;
    end
  end

  assign out0_pvld = br_pvld[0];
  assign out1_pvld = br_pvld[1];
  assign out0_pd   = buf_pd;
  assign out1_pd   = buf_pd;

endmodule

// File: tb/tb_nv_vld_rdy_fork2.sv
// Bench for nv_vld_rdy_fork2: directed scenarios plus a randomized run,
// checked against per-branch payload queues, on WIDTH=64 and WIDTH=1 copies.
module tb_nv_vld_rdy_fork2;

  localparam int W         = 64;
  localparam int N_RANDOM  = 10000;
  localparam int CYC_LIMIT = 80000;

  logic nvdla_core_clk = 1'b0;
  logic nvdla_core_rstn = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  logic         in_pvld = 1'b0;
  logic [W-1:0] in_pd = '0;
  logic         out0_prdy = 1'b0;
  logic         out1_prdy = 1'b0;

  logic         in_prdy, out0_pvld, out1_pvld;
  logic [W-1:0] out0_pd, out1_pd;
  logic         n_in_prdy, n_out0_pvld, n_out1_pvld;
  logic [0:0]   n_out0_pd, n_out1_pd;

  nv_vld_rdy_fork2 #(.WIDTH(W)) dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .in_pvld         (in_pvld),
    .in_prdy         (in_prdy),
    .in_pd           (in_pd),
    .out0_pvld       (out0_pvld),
    .out0_prdy       (out0_prdy),
    .out0_pd         (out0_pd),
    .out1_pvld       (out1_pvld),
    .out1_prdy       (out1_prdy),
    .out1_pd         (out1_pd)
  );

  nv_vld_rdy_fork2 #(.WIDTH(1)) dut_narrow (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .in_pvld         (in_pvld),
    .in_prdy         (n_in_prdy),
    .in_pd           (in_pd[0:0]),
    .out0_pvld       (n_out0_pvld),
    .out0_prdy       (out0_prdy),
    .out0_pd         (n_out0_pd),
    .out1_pvld       (n_out1_pvld),
    .out1_prdy       (out1_prdy),
    .out1_pd         (n_out1_pd)
  );

  // Reference: payloads each branch still owes, plus the last accepted payload.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] last_pd = '0;
  int           n_acc = 0;
  bit           checking = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then let
  // the model take the edge. want_rdy < 0 means no extra directed check.
  task automatic step(input logic rst_v, input logic v, input logic [W-1:0] pd,
                      input logic r0, input logic r1, input int want_rdy);
    logic exp_rdy;
    logic [W-1:0] lp;
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = rst_v;
    in_pvld   = v;
    in_pd     = pd;
    out0_prdy = r0;
    out1_prdy = r1;
    #1;
    exp_rdy = (q0.size() == 0 || r0) && (q1.size() == 0 || r1);
    lp = last_pd;
    if (checking) begin
      check("in_prdy",   in_prdy,   exp_rdy);
      check("out0_pvld", out0_pvld, q0.size() != 0);
      check("out1_pvld", out1_pvld, q1.size() != 0);
      check("out0_pd",   out0_pd,   lp);
      check("out1_pd",   out1_pd,   lp);
      check("w1_in_prdy",   n_in_prdy,   exp_rdy);
      check("w1_out0_pvld", n_out0_pvld, q0.size() != 0);
      check("w1_out1_pvld", n_out1_pvld, q1.size() != 0);
      check("w1_out0_pd",   n_out0_pd,   lp[0]);
      check("w1_out1_pd",   n_out1_pd,   lp[0]);
      if (want_rdy >= 0) check("dir_in_prdy", in_prdy, want_rdy[0]);
    end
    @(posedge nvdla_core_clk);
    if (!rst_v) begin
      q0.delete();
      q1.delete();
      last_pd = '0;
    end else begin
      if (q0.size() != 0 && r0) void'(q0.pop_front());
      if (q1.size() != 0 && r1) void'(q1.pop_front());
      if (v && exp_rdy) begin
        q0.push_back(pd);
        q1.push_back(pd);
        last_pd = pd;
        n_acc++;
      end
    end
  endtask

  initial begin
    int cyc;
    int target;

    // Reset with a payload already offered; DUT state is unknown until the edge.
    step(1'b0, 1'b1, 64'hA5, 1'b0, 1'b0, -1);
    step(1'b0, 1'b1, 64'hA5, 1'b0, 1'b0, -1);
    checking = 1'b1;
    // First cycle after release: reset outputs, and 0xA5 is accepted.
    step(1'b1, 1'b1, 64'hA5, 1'b1, 1'b1, 1);

    // Streaming with both branches ready.
    step(1'b1, 1'b1, 64'h1, 1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 64'h2, 1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 64'h3, 1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1);

    // Skew: branch 1 stalls three cycles while 0x11 waits upstream.
    step(1'b1, 1'b1, 64'h10, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 64'h11, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 64'h11, 1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1);

    // Double stall, then retire and accept in the same cycle.
    step(1'b1, 1'b1, 64'h20, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 64'h21, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 64'h21, 1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1);

    // Reset while branch 0 is done and branch 1 still owes 0x30.
    step(1'b1, 1'b1, 64'h30, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, -1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1);

    // Random traffic against the queue model.
    target = n_acc + N_RANDOM;
    cyc = 0;
    while (n_acc < target && cyc < CYC_LIMIT) begin
      step(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      cyc++;
    end
    check("rand_cycle_budget", W'(cyc < CYC_LIMIT), W'(1));

    // Drain: everything accepted must have been delivered on both branches.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1);
    check("drain_q0_empty", W'(q0.size()), W'(0));
    check("drain_q1_empty", W'(q1.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
